// File: rtl/cartoon_pkg.sv
// Shared types for the cartoon filter pipeline: pixel/window widths and the
// window_builder sequencing states.
package cartoon_pkg;

  localparam int PIX_W = 24;
  localparam int WIN_W = 9 * PIX_W;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [WIN_W-1:0] window_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } wb_state_t;

endpackage

// File: rtl/window_builder_line_buffer.sv
// line_buffer: fixed-depth pixel shift chain, advanced only when shift_en is high.
// dout is the pixel that entered DEPTH shifts ago.
module line_buffer #(
  parameter int DEPTH = 15,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             shift_en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] taps [DEPTH];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (shift_en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/window_builder.sv
// window_builder: turns a raster pixel stream into 3x3 windows for the mean filter.
// Optional build macro WINDOW_BUILDER_STALL_CNT_EN adds the stall_cnt output.
module window_builder #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int PIX_W = 24
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [PIX_W-1:0]      pix_in,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic [9*PIX_W-1:0]    win_data,
  output logic                  win_valid,
  output logic                  win_last,
  input  logic                  win_ready,
`ifdef WINDOW_BUILDER_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  output cartoon_pkg::wb_state_t dbg_state
);

  import cartoon_pkg::*;

  // Handshakes: a beat transfers on the rising edge where valid && ready are both
  // high; a presented window holds data/last stable until it transfers.

  localparam int WIN_BITS = 9 * PIX_W;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  wb_state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [PIX_W-1:0] w  [9];
  logic [PIX_W-1:0] nw [9];
  logic [WIN_BITS-1:0] next_win;
  logic [PIX_W-1:0] lb_a_dout, lb_b_dout;

  logic accept, take, emit, at_last;

  assign pix_ready = !(win_valid && !win_ready);
  assign accept    = pix_valid && pix_ready;
  // Beats arriving in IDLE without sof never touch the window or line buffers.
  assign take      = accept && (pix_sof || (state != IDLE));
  assign at_last   = (row == ROW_LAST) && (col == COL_LAST);
  assign emit      = accept && !pix_sof && (state != IDLE) &&
                     (row >= RW'(2)) && (col >= CW'(2));
  assign dbg_state = state;

  line_buffer #(.DEPTH(IMG_W - 1), .PIX_W(PIX_W)) u_lb_a (
    .clk(clk), .n_rst(n_rst), .shift_en(take), .din(w[8]), .dout(lb_a_dout)
  );

  line_buffer #(.DEPTH(IMG_W - 1), .PIX_W(PIX_W)) u_lb_b (
    .clk(clk), .n_rst(n_rst), .shift_en(take), .din(w[5]), .dout(lb_b_dout)
  );

  // Window after this beat's shift; lb_a/lb_b supply the pixels one/two rows up.
  always_comb begin
    nw[0] = w[1];
    nw[1] = w[2];
    nw[2] = lb_b_dout;
    nw[3] = w[4];
    nw[4] = w[5];
    nw[5] = lb_a_dout;
    nw[6] = w[7];
    nw[7] = w[8];
    nw[8] = pix_in;
    next_win = '0;
    for (int k = 0; k < 9; k++) next_win[WIN_BITS-1-PIX_W*k -: PIX_W] = nw[k];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < 9; k++) w[k] <= '0;
    end else if (take) begin
      for (int k = 0; k < 9; k++) w[k] <= nw[k];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else if (take) begin
      if (pix_sof) begin
        state <= FILL;
        col   <= CW'(1);
        row   <= '0;
      end else begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= at_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (state == FILL && row == RW'(1) && col == COL_LAST) state <= STREAM;
        else if (state == STREAM && at_last)                   state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_data  <= '0;
    end else if (emit) begin
      win_valid <= 1'b1;
      win_last  <= at_last;
      win_data  <= next_win;
    end else if (win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

`ifdef WINDOW_BUILDER_STALL_CNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cnt <= '0;
    end else if (accept && pix_sof) begin
      stall_cnt <= '0;
    end else if (win_valid && !win_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_window_builder.sv
// Scoreboard bench for window_builder on a 4x4 frame with pixel i = {i,i,i}.
module tb_window_builder;

  import cartoon_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic         clk;
  logic         n_rst;
  logic [23:0]  pix_in;
  logic         pix_valid;
  logic         pix_sof;
  logic         pix_ready;
  logic [215:0] win_data;
  logic         win_valid;
  logic         win_last;
  logic         win_ready;
  wb_state_t    dbg_state;
`ifdef WINDOW_BUILDER_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  window_builder #(.IMG_W(W), .IMG_H(H), .PIX_W(24)) dut (
    .clk(clk), .n_rst(n_rst),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(pix_ready),
    .win_data(win_data), .win_valid(win_valid), .win_last(win_last), .win_ready(win_ready),
`ifdef WINDOW_BUILDER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int windows_seen = 0;
  logic [216:0] exp_q[$];

  // Hand-computed windows of the 4x4 frame (centres 5, 6, 9, 10), positions 0..8.
  int tbl [4][9] = '{
    '{0, 1, 2, 4, 5, 6,  8,  9, 10},
    '{1, 2, 3, 5, 6, 7,  9, 10, 11},
    '{4, 5, 6, 8, 9, 10, 12, 13, 14},
    '{5, 6, 7, 9, 10, 11, 13, 14, 15}
  };

  function automatic logic [215:0] pack_win(input int idx);
    logic [215:0] r;
    logic [7:0] b;
    r = '0;
    for (int k = 0; k < 9; k++) begin
      b = 8'(tbl[idx][k]);
      r[215-24*k -: 24] = {b, b, b};
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [7:0] v, input logic sof);
    int waits;
    waits = 0;
    pix_in = {v, v, v};
    pix_sof = sof;
    pix_valid = 1'b1;
    @(negedge clk);
    while (!pix_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: pixel %0d never accepted", v);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < W * H; i++) begin
      if (i == 10) exp_q.push_back({1'b0, pack_win(0)});
      if (i == 11) exp_q.push_back({1'b0, pack_win(1)});
      if (i == 14) exp_q.push_back({1'b0, pack_win(2)});
      if (i == 15) exp_q.push_back({1'b1, pack_win(3)});
      send(8'(i), i == 0);
    end
  endtask

  task automatic drain_and_count(input string name);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_window_count"}, 256'(windows_seen), 256'(4));
    check({name, "_queue_empty"}, 256'(exp_q.size()), 256'(0));
    windows_seen = 0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (n_rst && win_valid && win_ready) begin
      windows_seen++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_window: got last=%0b data=%0h expected none", win_last, win_data);
      end else begin
        logic [216:0] e;
        e = exp_q.pop_front();
        if ({win_last, win_data} !== e) begin
          miscompares++;
          $display("FAIL window: got last=%0b data=%0h expected last=%0b data=%0h",
                   win_last, win_data, e[216], e[215:0]);
        end
      end
    end
  end

  initial begin
    int waits;
    n_rst = 1'b0;
    pix_in = '0;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    win_ready = 1'b1;
    #23 n_rst = 1'b1;
    @(posedge clk);
    #1;

    check("reset_win_valid", 256'(win_valid), 256'(0));
    check("reset_win_last", 256'(win_last), 256'(0));
    check("reset_win_data", 256'(win_data), 256'(0));
    check("reset_pix_ready", 256'(pix_ready), 256'(1));
    check("reset_state", 256'(dbg_state), 256'(IDLE));

    // basic frame
    send_frame();
    drain_and_count("basic");

    // backpressure on the first window for 5 cycles
    win_ready = 1'b0;
    fork
      send_frame();
      begin
        waits = 0;
        @(negedge clk);
        while (!win_valid && waits < 200) begin
          @(negedge clk);
          waits++;
        end
        check("bp_window_seen", 256'(win_valid), 256'(1));
        for (int k = 0; k < 5; k++) begin
          check("bp_pix_ready", 256'(pix_ready), 256'(0));
          check("bp_hold_data", 256'(win_data), 256'(pack_win(0)));
          @(posedge clk);
          #1;
          if (k < 4) @(negedge clk);
        end
        win_ready = 1'b1;
      end
    join
    drain_and_count("backpressure");
`ifdef WINDOW_BUILDER_STALL_CNT_EN
    check("stall_cnt", 256'(stall_cnt), 256'(5));
`endif

    // garbage before sof is dropped
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("garbage_pix_ready", 256'(pix_ready), 256'(1));
      send(8'hE0 + 8'(k), 1'b0);
      check("garbage_state", 256'(dbg_state), 256'(IDLE));
    end
    send_frame();
    drain_and_count("garbage");

    // restart with sof mid-frame (at i=7)
    for (int i = 0; i < 7; i++) send(8'(i), i == 0);
    check("restart_pre_state", 256'(dbg_state), 256'(FILL));
    send_frame();
    drain_and_count("restart");

    // asynchronous reset while a window is presented
    exp_q.push_back({1'b0, pack_win(0)});
    for (int i = 0; i <= 10; i++) send(8'(i), i == 0);
    @(negedge clk);
    check("areset_pre_valid", 256'(win_valid), 256'(1));
    #2 n_rst = 1'b0;
    #1;
    check("areset_win_valid", 256'(win_valid), 256'(0));
    check("areset_win_data", 256'(win_data), 256'(0));
    check("areset_win_last", 256'(win_last), 256'(0));
    exp_q.delete();
    windows_seen = 0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk);
    #1;
    send_frame();
    drain_and_count("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
